// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown timer with load, run/pause toggle, done state and alarm pulse.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   tick              - time-base enable pulse; TICK_DIV counted ticks make one second
//   load, load_*      - capture clamped preset digits and return to IDLE
//   start_pause       - toggles run/pause; ignored in DONE and at 00:00 in IDLE
//   min_t..sec_u      - registered remaining time, BCD
//   running, done     - state flags; alarm pulses in the first DONE cycle
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_min_t,
  input  logic [3:0] load_min_u,
  input  logic [3:0] load_sec_t,
  input  logic [3:0] load_sec_u,
  input  logic       start_pause,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done,
  output logic       alarm
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [7:0] TC = 8'(TICK_DIV - 1);
  state_t     state_q, state_d;
  logic [3:0] min_t_q, min_t_d, min_u_q, min_u_d, sec_t_q, sec_t_d, sec_u_q, sec_u_d;
  logic [3:0] dec_mt, dec_mu, dec_st, dec_su;
  logic [7:0] pre_q, pre_d;
  logic       alarm_q, alarm_d;
  logic       su_z, st_z, mu_z, is_zero, dec_zero, tc;
  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] m);
    return v > m ? m : v;
  endfunction
  // BCD borrow chain for a one-second decrement
  always_comb begin
    su_z     = sec_u_q == 4'd0;
    st_z     = sec_t_q == 4'd0;
    mu_z     = min_u_q == 4'd0;
    dec_su   = su_z ? 4'd9 : sec_u_q - 4'd1;
    dec_st   = su_z ? (st_z ? 4'd5 : sec_t_q - 4'd1) : sec_t_q;
    dec_mu   = (su_z && st_z) ? (mu_z ? 4'd9 : min_u_q - 4'd1) : min_u_q;
    dec_mt   = (su_z && st_z && mu_z) ? min_t_q - 4'd1 : min_t_q;
    is_zero  = {min_t_q, min_u_q, sec_t_q, sec_u_q} == 16'd0;
    dec_zero = {dec_mt, dec_mu, dec_st, dec_su} == 16'd0;
    // is_zero guard keeps the value from ever wrapping below 00:00
    tc       = state_q == RUN && tick && pre_q == TC && !is_zero;
  end
  always_comb begin
    state_d = state_q;
    min_t_d = min_t_q;
    min_u_d = min_u_q;
    sec_t_d = sec_t_q;
    sec_u_d = sec_u_q;
    pre_d   = pre_q;
    alarm_d = 1'b0;
    if (load) begin
      min_t_d = clamp(load_min_t, 4'd9);
      min_u_d = clamp(load_min_u, 4'd9);
      sec_t_d = clamp(load_sec_t, 4'd5);
      sec_u_d = clamp(load_sec_u, 4'd9);
      state_d = IDLE;
      pre_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE:  state_d = (start_pause && !is_zero) ? RUN : IDLE;
        RUN: begin
          if (tick) pre_d = tc ? 8'd0 : pre_q + 8'd1;
          if (tc) begin
            min_t_d = dec_mt;
            min_u_d = dec_mu;
            sec_t_d = dec_st;
            sec_u_d = dec_su;
          end
          // reaching 00:00 takes priority over a simultaneous pause request
          state_d = (tc && dec_zero) ? DONE : start_pause ? PAUSE : RUN;
          alarm_d = tc && dec_zero;
        end
        PAUSE: state_d = start_pause ? RUN : PAUSE;
        default: state_d = DONE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      min_t_q <= 4'd0;
      min_u_q <= 4'd0;
      sec_t_q <= 4'd0;
      sec_u_q <= 4'd0;
      pre_q   <= 8'd0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_t_q <= min_t_d;
      min_u_q <= min_u_d;
      sec_t_q <= sec_t_d;
      sec_u_q <= sec_u_d;
      pre_q   <= pre_d;
      alarm_q <= alarm_d;
    end
  end
  assign min_t   = min_t_q;
  assign min_u   = min_u_q;
  assign sec_t   = sec_t_q;
  assign sec_u   = sec_u_q;
  assign running = state_q == RUN;
  assign done    = state_q == DONE;
  assign alarm   = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer with TICK_DIV=1 and TICK_DIV=4 instances.
module tb_countdown_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b0, tick = 1'b0, load = 1'b0, start_pause = 1'b0;
  logic [15:0] ld = 16'd0;
  logic [3:0]  mt0, mu0, st0, su0, mt1, mu1, st1, su1;
  logic        r0, d0, a0, r1, d1, a1;
  typedef struct {
    bit          sel;
    logic [18:0] exp;
    int          id;
  } item_t;
  item_t sb[$];
  int errors = 0, checks = 0, step = 0;
  always #5 clk = ~clk;
  countdown_timer #(.TICK_DIV(1)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_min_t(ld[15:12]), .load_min_u(ld[11:8]), .load_sec_t(ld[7:4]), .load_sec_u(ld[3:0]),
    .start_pause(start_pause), .min_t(mt0), .min_u(mu0), .sec_t(st0), .sec_u(su0),
    .running(r0), .done(d0), .alarm(a0)
  );
  countdown_timer #(.TICK_DIV(4)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_min_t(ld[15:12]), .load_min_u(ld[11:8]), .load_sec_t(ld[7:4]), .load_sec_u(ld[3:0]),
    .start_pause(start_pause), .min_t(mt1), .min_u(mu1), .sec_t(st1), .sec_u(su1),
    .running(r1), .done(d1), .alarm(a1)
  );
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t e;
      logic [18:0] act;
      e   = sb.pop_front();
      act = e.sel ? {mt1, mu1, st1, su1, r1, d1, a1} : {mt0, mu0, st0, su0, r0, d0, a0};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL step%0d dut%0d: got time=%h run=%b done=%b alarm=%b, expected time=%h run=%b done=%b alarm=%b",
                 e.id, e.sel, act[18:3], act[2], act[1], act[0], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end
  task automatic cyc(input bit s, input bit r, input bit l, input bit sp, input bit tk,
                     input logic [15:0] ldv, input logic [15:0] et, input bit er, input bit ed, input bit ea);
    item_t e;
    reset = r; load = l; start_pause = sp; tick = tk; ld = ldv;
    @(posedge clk);
    step++;
    e.sel = s; e.exp = {et, er, ed, ea}; e.id = step;
    sb.push_back(e);
    #1;
  endtask
  initial begin
    cyc(0, 1, 1, 1, 1, 16'h1234, 16'h0000, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'h0003, 16'h0003, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h0003, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 16'h0000, 16'h0003, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
    cyc(0, 0, 1, 1, 0, 16'h0005, 16'h0005, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h0005, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 16'h0000, 16'h1000, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h0959, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 16'h0000, 16'h0100, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h0059, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'hFF7C, 16'h9959, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 16'h0000, 16'h9959, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h9958, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 16'h0000, 16'h9957, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0000, 16'h9957, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 16'h0000, 16'h9957, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'h0500, 16'h0500, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 16'h0000, 16'h0500, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 16'h0000, 16'h0010, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 16'h0000, 16'h0010, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 16'h0000, 16'h0010, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 16'h0000, 16'h0010, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 16'h0000, 16'h0010, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 16'h0000, 16'h0010, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 16'h0000, 16'h0010, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 16'h0000, 16'h0009, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 16'h0000, 16'h0009, 1, 0, 0);
    reset = 1'b0; load = 1'b0; start_pause = 1'b0; tick = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 1, meaning: number of tick pulses per one-second decrement; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 tick  input  1  single-cycle enable pulse from the time base.
REQ-005 load  input  1  single-cycle pulse; captures the load_* preset digits.
REQ-006 load_min_t  input  4  preset minutes tens, BCD.
REQ-007 load_min_u  input  4  preset minutes units, BCD.
REQ-008 load_sec_t  input  4  preset seconds tens, BCD.
REQ-009 load_sec_u  input  4  preset seconds units, BCD.
REQ-010 start_pause  input  1  single-cycle pulse; toggles run/pause.
REQ-011 min_t, min_u, sec_t, sec_u  output  4 each  current remaining time, BCD, registered.
REQ-012 running  output  1  high while in RUN.
REQ-013 done  output  1  high while in DONE.
REQ-014 alarm  output  1  one-cycle pulse on entry to DONE.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, PAUSE, DONE.
REQ-016 On load, each digit SHALL be clamped: min_t, min_u, sec_u above 9 become 9; sec_t above 5 becomes 5.
REQ-017 load SHALL take effect in any state: digits are captured next cycle, the state goes to IDLE, and the prescaler clears.
REQ-018 If load and start_pause occur in the same cycle, load SHALL win and start_pause SHALL be ignored.
REQ-019 IDLE to RUN: on start_pause, only if the held value is not 00:00; otherwise the block SHALL stay in IDLE.
REQ-020 RUN to PAUSE: on start_pause; the digits hold and the prescaler count is retained.
REQ-021 PAUSE to RUN: on start_pause; the prescaler resumes from its retained count.
REQ-022 The prescaler SHALL count tick pulses only in RUN; at count TICK_DIV it SHALL issue one decrement and return to 0.
REQ-023 A tick arriving in the cycle that RUN is entered SHALL NOT be counted.
REQ-024 Each decrement SHALL form a BCD borrow chain:
- sec_u 0 becomes 9 and borrows from sec_t;
- sec_t 0 becomes 5 and borrows from min_u;
- min_u 0 becomes 9 and borrows from min_t;
- otherwise the digit decrements by 1.
REQ-025 A decrement that produces 00:00 SHALL move the state to DONE in the same clock edge as the digit update.
REQ-026 alarm SHALL be high exactly in the first cycle of DONE.
REQ-027 The value SHALL never wrap below 00:00; no decrement SHALL occur outside RUN.
REQ-028 In DONE, start_pause SHALL be ignored and only load or reset SHALL exit.
REQ-029 If start_pause and a prescaler terminal count occur in the same RUN cycle, the decrement SHALL be applied and the state SHALL go to PAUSE.
REQ-030 Outputs SHALL change only on posedge clk, with no combinational path from any input to any output.

Reset
REQ-031 When reset=1 at posedge clk, the block SHALL set:
- all digits to 0;
- state to IDLE;
- prescaler to 0;
- running, done and alarm to 0.
REQ-032 reset SHALL override load, start_pause and tick in the same cycle.
REQ-033 reset asserted mid-RUN SHALL abort the countdown without generating alarm.

Verification
REQ-034 TICK_DIV=1, load 00:03, start_pause, then 3 ticks: outputs read 00:02, 00:01, 00:00; done=1 and alarm pulses for 1 cycle on the third tick edge.
REQ-035 Load 10:00, start, then 1 tick: output reads 09:59 (full borrow chain).
REQ-036 Load digits F,F,7,C: output reads 99:59 after clamping; start plus 1 tick gives 99:58.
REQ-037 TICK_DIV=4, load 00:10, start, then 2 ticks, pause, 5 ticks, resume, then 2 ticks: output reads 00:09 only after the 4th counted tick; no change occurs while paused.
REQ-038 Load 00:00, then start_pause: the block stays in IDLE with running=0 and done=0; separately, reset asserted during RUN at 05:00 gives all zeros next cycle and alarm stays 0.
REQ-039 In DONE, start_pause leaves the state DONE; load 00:05 in the same cycle as start_pause gives state IDLE with 00:05 displayed.
